baseline_detector: RTL and testbench

// Consumer side of the baseline pipeline. It latches each new long-window

---
 rtl/baseline_detector.sv | 161 ++++++++++++++++
 tb/tb_baseline_detector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/baseline_detector.sv
// Scales each captured long-window baseline into a detection threshold and
// debounces short-window feature comparisons into a seizure alarm with onset pulse.
module baseline_detector #(
    parameter int feat_width  = 25,
    parameter int base_width  = 37,
    parameter int ratio_width = 8,
    parameter int ratio_frac  = 4,
    parameter int on_count    = 5,
    parameter int off_count   = 10,
    parameter int cnt_width   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [base_width-1:0]  base_din,
    input  logic                   base_valid,
    input  logic [feat_width-1:0]  feat_din,
    input  logic                   feat_valid,
    input  logic [ratio_width-1:0] ratio,
    output logic                   base_ok,
    output logic                   exceed,
    output logic                   alarm_valid,
    output logic                   alarm,
    output logic                   onset
);
    localparam int THR_W = base_width + ratio_width + 1;
    localparam logic [cnt_width-1:0] ON_C  = cnt_width'(on_count);
    localparam logic [cnt_width-1:0] OFF_C = cnt_width'(off_count);

    typedef enum logic [2:0] {IDLE, QUIET, PENDING, ALARM, RELEASE} state_t;

    state_t                    state_q, state_d, cur_state;
    logic [cnt_width-1:0]      cnt_q, cnt_d, cnt_inc;
    logic signed [THR_W-1:0]   thr_q, thr_d;
    logic signed [THR_W-1:0]   base_ext, ratio_ext, product, scaled, feat_ext;
    logic                      base_ok_q, base_ok_d;
    logic                      exceed_q, exceed_d;
    logic                      alarm_valid_q, alarm_valid_d;
    logic                      alarm_q, alarm_d;
    logic                      onset_q, onset_d;
    logic                      hit, processed;

    always_comb begin
        base_ext  = {{(THR_W-base_width){base_din[base_width-1]}}, base_din};
        ratio_ext = {{(THR_W-ratio_width){1'b0}}, ratio};
        product   = base_ext * ratio_ext;
        scaled    = product >>> ratio_frac;
        feat_ext  = {{(THR_W-feat_width){feat_din[feat_width-1]}}, feat_din};
        hit       = feat_ext > thr_q;
        processed = feat_valid & ~en & base_ok_q;
        cnt_inc   = (cnt_q == {cnt_width{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        // A sample arriving before the IDLE->QUIET step lands is judged as QUIET
        cur_state = (state_q == IDLE) ? QUIET : state_q;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        thr_d         = thr_q;
        base_ok_d     = base_ok_q;
        exceed_d      = exceed_q;
        alarm_d       = alarm_q;
        alarm_valid_d = 1'b0;
        onset_d       = 1'b0;
        if (!en) begin
            if (base_valid) begin
                thr_d     = scaled;
                base_ok_d = 1'b1;
            end
            if (state_q == IDLE && base_ok_q) begin
                state_d = QUIET;
            end
            if (processed) begin
                exceed_d      = hit;
                alarm_valid_d = 1'b1;
                case (cur_state)
                    QUIET: begin
                        state_d = QUIET;
                        if (hit) begin
                            if (on_count == 1) begin
                                state_d = ALARM;
                                cnt_d   = '0;
                                onset_d = 1'b1;
                            end else begin
                                state_d = PENDING;
                                cnt_d   = cnt_width'(1);
                            end
                        end
                    end
                    PENDING: begin
                        if (!hit) begin
                            state_d = QUIET;
                            cnt_d   = '0;
                        end else if (cnt_inc == ON_C) begin
                            state_d = ALARM;
                            cnt_d   = '0;
                            onset_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    ALARM: begin
                        if (!hit) begin
                            if (off_count == 1) begin
                                state_d = QUIET;
                                cnt_d   = '0;
                            end else begin
                                state_d = RELEASE;
                                cnt_d   = cnt_width'(1);
                            end
                        end
                    end
                    RELEASE: begin
                        if (hit) begin
                            state_d = ALARM;
                            cnt_d   = '0;
                        end else if (cnt_inc == OFF_C) begin
                            state_d = QUIET;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        state_d = QUIET;
                        cnt_d   = '0;
                    end
                endcase
            end
            alarm_d = (state_d == ALARM) || (state_d == RELEASE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            thr_q         <= '0;
            base_ok_q     <= 1'b0;
            exceed_q      <= 1'b0;
            alarm_q       <= 1'b0;
            alarm_valid_q <= 1'b0;
            onset_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            thr_q         <= thr_d;
            base_ok_q     <= base_ok_d;
            exceed_q      <= exceed_d;
            alarm_q       <= alarm_d;
            alarm_valid_q <= alarm_valid_d;
            onset_q       <= onset_d;
        end
    end

    assign base_ok     = base_ok_q;
    assign exceed      = exceed_q;
    assign alarm_valid = alarm_valid_q;
    assign alarm       = alarm_q;
    assign onset       = onset_q;
endmodule

// File: tb/tb_baseline_detector.sv
// Directed bench for baseline_detector: threshold capture, debounce on/off,
// same-cycle baseline update, enable hold and reset behaviour.
module tb_baseline_detector;
    localparam int FW = 25;
    localparam int BW = 37;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [BW-1:0] base_din = '0;
    logic          base_valid = 1'b0;
    logic [FW-1:0] feat_din = '0;
    logic          feat_valid = 1'b0;
    logic [RW-1:0] ratio = 8'd32;
    logic          base_ok, exceed, alarm_valid, alarm, onset;

    int checks = 0;
    int failures = 0;

    baseline_detector dut (
        .clk(clk), .rst(rst), .en(en),
        .base_din(base_din), .base_valid(base_valid),
        .feat_din(feat_din), .feat_valid(feat_valid),
        .ratio(ratio),
        .base_ok(base_ok), .exceed(exceed), .alarm_valid(alarm_valid),
        .alarm(alarm), .onset(onset)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; base_valid = 1'b0; feat_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_base(input int b);
        @(negedge clk);
        base_din = BW'(b); base_valid = 1'b1;
        @(negedge clk);
        base_valid = 1'b0;
    endtask

    // Returns on the negedge following the processing edge
    task automatic pulse_feat(input int f);
        @(negedge clk);
        feat_din = FW'(f); feat_valid = 1'b1;
        @(negedge clk);
        feat_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ratio = 8'd32;
        load_base(100);
        for (int i = 0; i < 5; i++) pulse_feat(250);
        checks++;
        if (alarm !== 1'b1) begin failures++; $display("FAIL reset_prealarm alarm=%b exp=1", alarm); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({base_ok, exceed, alarm_valid, alarm, onset} !== 5'b0) begin
            failures++;
            $display("FAIL reset_async outs=%b exp=00000", {base_ok, exceed, alarm_valid, alarm, onset});
        end
        @(negedge clk) rst = 1'b1;
        pulse_feat(999);
        checks++;
        if (alarm_valid !== 1'b0 || base_ok !== 1'b0) begin
            failures++;
            $display("FAIL reset_nobase alarm_valid=%b base_ok=%b exp=0 0", alarm_valid, base_ok);
        end
        $display("test_reset done");
    endtask

    task automatic test_onset();
        do_reset();
        ratio = 8'd32;
        load_base(100);
        checks++;
        if (base_ok !== 1'b1) begin failures++; $display("FAIL onset_baseok base_ok=%b exp=1", base_ok); end
        for (int i = 0; i < 5; i++) begin
            pulse_feat(250);
            checks++;
            if (alarm_valid !== 1'b1 || exceed !== 1'b1 || alarm !== (i == 4) || onset !== (i == 4)) begin
                failures++;
                $display("FAIL onset_seq i=%0d av=%b ex=%b alarm=%b onset=%b exp 1 1 %b %b",
                         i, alarm_valid, exceed, alarm, onset, i == 4, i == 4);
            end
        end
        @(negedge clk);
        checks++;
        if (onset !== 1'b0 || alarm_valid !== 1'b0 || alarm !== 1'b1) begin
            failures++;
            $display("FAIL onset_pulse onset=%b av=%b alarm=%b exp 0 0 1", onset, alarm_valid, alarm);
        end
        $display("test_onset done");
    endtask

    task automatic test_interrupted();
        do_reset();
        ratio = 8'd32;
        load_base(100);
        for (int i = 0; i < 9; i++) begin
            pulse_feat((i == 4) ? 200 : 250);
            checks++;
            if (alarm !== 1'b0 || onset !== 1'b0 || exceed !== (i != 4)) begin
                failures++;
                $display("FAIL interrupted i=%0d alarm=%b onset=%b exceed=%b exp 0 0 %b",
                         i, alarm, onset, exceed, i != 4);
            end
        end
        $display("test_interrupted done");
    endtask

    task automatic test_release();
        do_reset();
        ratio = 8'd32;
        load_base(100);
        for (int i = 0; i < 5; i++) pulse_feat(250);
        for (int i = 0; i < 9; i++) pulse_feat(150);
        checks++;
        if (alarm !== 1'b1) begin failures++; $display("FAIL release_9 alarm=%b exp=1", alarm); end
        pulse_feat(250);
        checks++;
        if (alarm !== 1'b1 || onset !== 1'b0) begin
            failures++;
            $display("FAIL release_rehit alarm=%b onset=%b exp 1 0", alarm, onset);
        end
        for (int i = 0; i < 10; i++) begin
            pulse_feat(150);
            checks++;
            if (alarm !== (i != 9) || onset !== 1'b0) begin
                failures++;
                $display("FAIL release_clear i=%0d alarm=%b onset=%b exp %b 0", i, alarm, onset, i != 9);
            end
        end
        $display("test_release done");
    endtask

    task automatic test_same_cycle();
        do_reset();
        ratio = 8'd32;
        load_base(100);
        @(negedge clk);
        base_din = BW'(200); base_valid = 1'b1;
        feat_din = FW'(250); feat_valid = 1'b1;
        @(negedge clk);
        base_valid = 1'b0; feat_valid = 1'b0;
        checks++;
        if (exceed !== 1'b1 || alarm_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_old exceed=%b av=%b exp 1 1", exceed, alarm_valid);
        end
        pulse_feat(250);
        checks++;
        if (exceed !== 1'b0) begin failures++; $display("FAIL same_cycle_new exceed=%b exp=0", exceed); end
        $display("test_same_cycle done");
    endtask

    task automatic test_signed();
        do_reset();
        ratio = 8'd16;
        load_base(-100);
        pulse_feat(-50);
        checks++;
        if (exceed !== 1'b1) begin failures++; $display("FAIL signed_above exceed=%b exp=1", exceed); end
        pulse_feat(-100);
        checks++;
        if (exceed !== 1'b0) begin failures++; $display("FAIL signed_equal exceed=%b exp=0", exceed); end
        $display("test_signed done");
    endtask

    task automatic test_enable_hold();
        do_reset();
        ratio = 8'd32;
        load_base(100);
        for (int i = 0; i < 3; i++) pulse_feat(250);
        @(negedge clk);
        en = 1'b1;
        base_din = BW'(10000); feat_din = FW'(250);
        for (int i = 0; i < 20; i++) begin
            base_valid = i[0];
            feat_valid = ~i[0];
            @(negedge clk);
            checks++;
            if (alarm_valid !== 1'b0 || alarm !== 1'b0 || exceed !== 1'b1 || onset !== 1'b0 || base_ok !== 1'b1) begin
                failures++;
                $display("FAIL enable_hold i=%0d av=%b alarm=%b exceed=%b onset=%b base_ok=%b exp 0 0 1 0 1",
                         i, alarm_valid, alarm, exceed, onset, base_ok);
            end
        end
        base_valid = 1'b0; feat_valid = 1'b0; en = 1'b0;
        pulse_feat(250);
        checks++;
        if (alarm !== 1'b0) begin failures++; $display("FAIL enable_cnt4 alarm=%b exp=0", alarm); end
        pulse_feat(250);
        checks++;
        if (alarm !== 1'b1 || onset !== 1'b1) begin
            failures++;
            $display("FAIL enable_cnt5 alarm=%b onset=%b exp 1 1", alarm, onset);
        end
        $display("test_enable_hold done");
    endtask

    initial begin
        #1;
        checks++;
        if ({base_ok, exceed, alarm_valid, alarm, onset} !== 5'b0) begin
            failures++;
            $display("FAIL initial_reset outs=%b exp=00000", {base_ok, exceed, alarm_valid, alarm, onset});
        end
        test_reset();
        test_onset();
        test_interrupted();
        test_release();
        test_same_cycle();
        test_signed();
        test_enable_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
